// File: rtl/lifo_stack_pkg.sv
// Shared constants and operation decode for the CPU data and return-address stacks.
package lifo_stack_pkg;

    localparam int unsigned DATA_WIDTH       = 8;
    localparam int unsigned PC_WIDTH         = 11;
    localparam int unsigned DATA_STACK_DEPTH = 16;
    localparam int unsigned PC_STACK_DEPTH   = 16;

    typedef enum logic [1:0] {
        OpIdle,
        OpPush,
        OpPop,
        OpReplace
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        stack_op_e op;
        case ({push, pop})
            2'b10:   op = OpPush;
            2'b01:   op = OpPop;
            2'b11:   op = OpReplace;
            default: op = OpIdle;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Register-array storage with one write port and one asynchronous read port.
module stack_mem #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the pointer logic masks stale entries.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// Synchronous LIFO with combinational top-of-stack and sticky overflow/underflow flags.
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_enable,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_enable,
    output logic [WIDTH-1:0] pop_data,
    input  logic             clear,
    input  logic             err_clear,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             is_empty, is_full;
    logic             we;
    logic [PTR_W-1:0] waddr, top_addr;
    logic [WIDTH-1:0] rdata;
    stack_op_e        op;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_COUNT);
    // Wraps to DEPTH-1 when empty; the read is masked in that case.
    assign top_addr = count_q[PTR_W-1:0] - 1'b1;
    assign op       = decode_op(push_enable, pop_enable);

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q & ~err_clear;
        underflow_d = underflow_q & ~err_clear;
        we          = 1'b0;
        waddr       = count_q[PTR_W-1:0];

        if (!clear) begin
            unique case (op)
                OpPush: begin
                    if (is_full) begin
                        overflow_d = 1'b1;
                    end else begin
                        we      = 1'b1;
                        count_d = count_q + 1'b1;
                    end
                end
                OpPop: begin
                    if (is_empty) begin
                        underflow_d = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
                OpReplace: begin
                    we = 1'b1;
                    if (is_empty) begin
                        // Push lands in slot 0; the pop half has nothing to take.
                        count_d     = count_q + 1'b1;
                        underflow_d = 1'b1;
                    end else begin
                        waddr = top_addr;
                    end
                end
                default: ;
            endcase
        end else begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (push_data),
        .raddr (top_addr),
        .rdata (rdata)
    );

    assign pop_data  = is_empty ? '0 : rdata;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Synchronous LIFO that answers the decoder's push/pop requests.
- One parameterised block serves both CPU stacks:
  - data stack: WIDTH=8, fed by PSH/POP;
  - return-address stack: WIDTH=11, fed by CAL/RTN.
- Top-of-stack is presented combinationally so the decoder can consume it in the same cycle it asserts pop.
- Full/empty status and sticky overflow/underflow error flags are exported for debug and interrupt logic.

Parameters:
- WIDTH, 8, data word width (11 for the return-address instance).
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- PTR_W, clog2(DEPTH), localparam; stack pointer width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push_enable  in  1  push push_data this cycle.
- push_data  in  WIDTH  word to push.
- pop_enable  in  1  pop the top entry this cycle.
- pop_data  out  WIDTH  current top-of-stack (combinational).
- clear  in  1  synchronous flush of all entries.
- err_clear  in  1  clears the sticky error flags.
- count  out  PTR_W+1  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky; set by a rejected push.
- underflow  out  1  sticky; set by a rejected pop.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count=0, overflow=0, underflow=0; outputs read empty=1, full=0, pop_data=0.
  - Storage contents are not reset.
- Storage: DEPTH x WIDTH register array. Write address = count[PTR_W-1:0]. Top entry = count-1.
- pop_data:
  - mem[count-1] whenever count>0; 0 when empty.
  - Purely combinational from registered state, with no path from push/pop inputs.
  - During a pop cycle it shows the entry being removed.
- All state updates on the rising clk edge. Priority order: clear > push/pop.
- clear=1: count<=0. push/pop that cycle are ignored and raise no errors. Error flags are unaffected.
- push only:
  - not full: mem[count]<=push_data, count+1.
  - full: no state change; overflow<=1.
- pop only:
  - not empty: count-1.
  - empty: no change; underflow<=1.
- push and pop in the same cycle:
  - count>0 (including full): replace top, mem[count-1]<=push_data, count unchanged, no error. pop_data in that cycle shows the old top.
  - empty: the push succeeds (mem[0]<=push_data, count=1); the pop is rejected and underflow<=1.
- err_clear: overflow<=0, underflow<=0. If a new error occurs in the same cycle, set wins.
- Latency: a pushed value is visible on pop_data the cycle after the push edge.
- Count arithmetic is PTR_W+1 bits; it never wraps because both boundaries are guarded.
- Return-address usage: the pushed value is the return address. A pop concurrent with a jump must deliver the address in the same cycle, which the combinational pop_data guarantees.
- No X propagation: pop_data must be 0, not a stale or uninitialised entry, whenever empty=1.

Decomposition:
- global_params.vh gains:
  - DATA_STACK_DEPTH=16 and PC_STACK_DEPTH=16;
  - PC_WIDTH=11 and DATA_WIDTH=8.
- Both stack instances and the decoder port widths use these constants.
- One sub-module: stack_mem.
  - Single write port and single asynchronous read port register array.
  - Ports: clk, we, waddr, wdata, raddr, rdata.
  - Keeps the pointer/flag logic in lifo_stack independent of the storage style (flops now, LUTRAM later).

Test Plan:
- Reset then idle:
  - Required: empty=1, full=0, count=0, pop_data=0, overflow=0, underflow=0.
  - Assert rst_n low mid-operation with count=5: count=0 immediately, without waiting for a clock edge.
- Push 0x11, 0x22, 0x33, then pop 3 times:
  - pop_data reads 0x33, 0x22, 0x11 in the respective pop cycles.
  - Afterwards empty=1 and pop_data=0.
- Push DEPTH (16) values 0x00..0x0F:
  - full=1, count=16.
  - 17th push of 0xAA: count stays 16, overflow=1, pop_data=0x0F.
  - err_clear: overflow=0.
- Pop when empty: underflow=1, count=0. Simultaneous push 0x5A + pop when empty: count=1, pop_data=0x5A next cycle, underflow=1.
- With stack [0x01,0x02], simultaneous push 0x99 + pop:
  - pop_data=0x02 during the cycle.
  - Next cycle count=2, pop_data=0x99.
  - Repeat with the stack full: no overflow.
- Priority and flag races:
  - clear with push_enable=1 and count=4: count=0, no overflow.
  - err_clear in the same cycle as a pop on empty: underflow ends 1.
  - WIDTH=11 instance: push 0x7FF, pop returns 0x7FF.
